pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor, the wide successor to the team's 4-bit CLA group. Operands are split into 4-bit lookahead groups. Each pipeline stage resolves GROUPS_PER_STAGE groups, and the carry between stages is registered. A valid/ready handshake on both sides lets the block feed the multiplier's final-adder path and other streaming datapaths with backpressure.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_group4.sv | 29 ++
 rtl/pipelined_cla_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined CLA adder.
// Offsets index the triangular skew/deskew register banks flattened into vectors.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int calc_num_stages(input int width, input int gps);
        return width / (GROUP_W * gps);
    endfunction

    function automatic bit width_ok(input int width, input int gps);
        return (gps > 0) && (width > 0) && ((width % (GROUP_W * gps)) == 0);
    endfunction

    // Stage k keeps the not-yet-added slices k+1..n-1 of each operand.
    function automatic int op_off(input int k, input int n, input int sw);
        return sw * (k * (n - 1) - (k * (k - 1)) / 2);
    endfunction

    // Stage k keeps the finished sum slices 0..k.
    function automatic int sum_off(input int k, input int sw);
        return sw * ((k * (k + 1)) / 2);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: internal carries by lookahead, group P/G for the
// next level, and the carry into bit 3 for signed-overflow detection.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g,
    output logic       c3
);

    logic [3:0] pb, gb;
    logic       c1, c2;

    always_comb begin
        pb = a ^ b;
        gb = a & b;
        c1 = gb[0] | (pb[0] & cin);
        c2 = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
        c3 = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
           | (pb[2] & pb[1] & pb[0] & cin);
        sum = pb ^ {c3, c2, c1, cin};
        p = &pb;
        g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
          | (pb[3] & pb[2] & pb[1] & gb[0]);
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// The whole pipe advances on one enable, so a stalled output freezes every stage.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SW         = GROUP_W * GROUPS_PER_STAGE;
    localparam int NUM_STAGES = calc_num_stages(WIDTH, GROUPS_PER_STAGE);
    localparam int OPS_TOT    = op_off(NUM_STAGES - 1, NUM_STAGES, SW);
    localparam int OPS_W      = (OPS_TOT > 0) ? OPS_TOT : 1;
    localparam int SUM_TOT    = sum_off(NUM_STAGES - 1, SW) + WIDTH;

    if (!width_ok(WIDTH, GROUPS_PER_STAGE)) begin : g_bad_width
        $error("WIDTH must be a multiple of 4*GROUPS_PER_STAGE");
    end

    logic [WIDTH-1:0]      a_eff, b_eff;
    logic                  cin_eff, en, acc;
    logic [NUM_STAGES-1:0] vld_d, vld_q;
    logic [OPS_W-1:0]      opa_q, opb_q;
    logic [SUM_TOT-1:0]    sum_q;
    logic [NUM_STAGES-1:0] c_q;
    logic                  cmsb_q;
    wire  [OPS_W-1:0]      opa_d, opb_d;
    wire  [SUM_TOT-1:0]    sum_d;
    wire  [NUM_STAGES-1:0] c_d;
    wire                   cmsb_d;

    assign en       = !vld_q[NUM_STAGES-1] || out_ready;
    assign in_ready = en;
    assign acc      = in_valid && en;
    assign a_eff    = in_a;
    assign b_eff    = in_b ^ {WIDTH{in_sub}};
    assign cin_eff  = in_sub | in_cin;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = acc;
        for (int k = 1; k < NUM_STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [SW-1:0]               sa, sb, ssum;
        logic                        scin;
        logic [GROUPS_PER_STAGE:0]   gc;
        logic [GROUPS_PER_STAGE-1:0] gp, gg;
        // Only the top group's bit-3 carry of the last stage is consumed.
        logic [GROUPS_PER_STAGE-1:0] c3_unused;

        if (k == 0) begin : g_first
            assign sa   = a_eff[SW-1:0];
            assign sb   = b_eff[SW-1:0];
            assign scin = cin_eff;
            assign sum_d[SW-1:0] = ssum;
            if (NUM_STAGES > 1) begin : g_fwd
                assign opa_d[0 +: SW*(NUM_STAGES-1)] = a_eff[WIDTH-1:SW];
                assign opb_d[0 +: SW*(NUM_STAGES-1)] = b_eff[WIDTH-1:SW];
            end
        end else begin : g_next
            localparam int PO = op_off(k - 1, NUM_STAGES, SW);
            assign sa   = opa_q[PO +: SW];
            assign sb   = opb_q[PO +: SW];
            assign scin = c_q[k-1];
            assign sum_d[sum_off(k, SW) +: SW*(k+1)] =
                {ssum, sum_q[sum_off(k - 1, SW) +: SW*k]};
            if (k < NUM_STAGES - 1) begin : g_fwd
                localparam int NO = op_off(k, NUM_STAGES, SW);
                assign opa_d[NO +: SW*(NUM_STAGES-1-k)] = opa_q[PO+SW +: SW*(NUM_STAGES-1-k)];
                assign opb_d[NO +: SW*(NUM_STAGES-1-k)] = opb_q[PO+SW +: SW*(NUM_STAGES-1-k)];
            end
        end

        // Group carries in flat sum-of-products form, no ripple across groups.
        always_comb begin
            logic pp, cc;
            gc    = '0;
            gc[0] = scin;
            for (int g = 1; g <= GROUPS_PER_STAGE; g++) begin
                pp = 1'b1;
                cc = 1'b0;
                for (int j = g - 1; j >= 0; j--) begin
                    cc = cc | (gg[j] & pp);
                    pp = pp & gp[j];
                end
                gc[g] = cc | (scin & pp);
            end
        end

        for (genvar g = 0; g < GROUPS_PER_STAGE; g++) begin : g_grp
            cla_group4 u_grp (
                .a   (sa[g*GROUP_W +: GROUP_W]),
                .b   (sb[g*GROUP_W +: GROUP_W]),
                .cin (gc[g]),
                .sum (ssum[g*GROUP_W +: GROUP_W]),
                .p   (gp[g]),
                .g   (gg[g]),
                .c3  (c3_unused[g])
            );
        end

        assign c_d[k] = gc[GROUPS_PER_STAGE];
        if (k == NUM_STAGES - 1) begin : g_last
            assign cmsb_d = c3_unused[GROUPS_PER_STAGE-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            sum_q  <= '0;
            c_q    <= '0;
            cmsb_q <= 1'b0;
        end else if (en) begin
            vld_q  <= vld_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            sum_q  <= sum_d;
            c_q    <= c_d;
            cmsb_q <= cmsb_d;
        end
    end

    assign out_valid = vld_q[NUM_STAGES-1];
    assign out_sum   = sum_q[SUM_TOT-1 -: WIDTH];
    assign out_cout  = c_q[NUM_STAGES-1];
    assign out_ovf   = cmsb_q ^ c_q[NUM_STAGES-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: a 16-bit default instance and a 32-bit,
// two-groups-per-stage instance run in lockstep on shared stimulus.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
    logic [31:0] in_a = '0, in_b = '0;
    logic        i16_ready, o16_valid, o16_cout, o16_ovf;
    logic [15:0] o16_sum;
    logic        i32_ready, o32_valid, o32_cout, o32_ovf;
    logic [31:0] o32_sum;

    int total = 0, bad = 0, cyc = 0;
    bit chk_lat = 1'b1;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        int          t;
    } beat_t;
    beat_t q16[$], q32[$];

    always #5 clk = ~clk;

    pipelined_cla_adder u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i16_ready),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(o16_valid), .out_ready(out_ready), .out_sum(o16_sum),
        .out_cout(o16_cout), .out_ovf(o16_ovf)
    );

    pipelined_cla_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i32_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(o32_valid), .out_ready(out_ready), .out_sum(o32_sum),
        .out_cout(o32_cout), .out_ovf(o32_ovf)
    );

    // Plain integer arithmetic: returns {ovf, cout, sum} for a w-bit operation.
    function automatic logic [33:0] ref_calc(input int w, input logic [31:0] a, b,
                                             input logic cin, sub);
        longint m, h, ua, ub, sa, sb, ci, r, sr;
        logic co, ov;
        m  = longint'(1) << w;
        h  = m / 2;
        ua = longint'({32'h0, a}) & (m - 1);
        ub = longint'({32'h0, b}) & (m - 1);
        ci = cin ? 1 : 0;
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        if (sub) begin
            r  = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + ci;
            co = (r >= m);
            sr = sa + sb + ci;
        end
        ov = (sr >= h) || (sr < -h);
        r  = r & (m - 1);
        return {ov, co, r[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input int w);
        logic v, co, ov;
        logic [31:0] s;
        logic [33:0] x;
        int n;
        beat_t e;
        v  = (w == 16) ? o16_valid : o32_valid;
        s  = (w == 16) ? {16'h0, o16_sum} : o32_sum;
        co = (w == 16) ? o16_cout : o32_cout;
        ov = (w == 16) ? o16_ovf : o32_ovf;
        n  = (w == 16) ? q16.size() : q32.size();
        if (!v) return;
        chk($sformatf("out%0d has pending beat", w), 64'(n != 0), 64'd1);
        if (n == 0) return;
        if (w == 16) e = q16[0];
        else         e = q32[0];
        x = ref_calc(w, e.a, e.b, e.cin, e.sub);
        chk($sformatf("sum%0d cyc%0d", w, cyc), 64'(s), 64'(x[31:0]));
        chk($sformatf("cout%0d cyc%0d", w, cyc), 64'(co), 64'(x[32]));
        chk($sformatf("ovf%0d cyc%0d", w, cyc), 64'(ov), 64'(x[33]));
        if (out_ready) begin
            if (chk_lat) chk($sformatf("latency%0d", w), 64'(cyc - e.t), 64'd4);
            if (w == 16) void'(q16.pop_front());
            else         void'(q32.pop_front());
        end
    endtask

    // One clock: check outputs and record accepts mid-cycle, then advance.
    task automatic tick();
        @(negedge clk);
        check_out(16);
        check_out(32);
        if (in_valid && i16_ready) q16.push_back('{a: in_a, b: in_b, cin: in_cin, sub: in_sub, t: cyc});
        if (in_valid && i32_ready) q32.push_back('{a: in_a, b: in_b, cin: in_cin, sub: in_sub, t: cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, b, input logic ci, sb);
        in_a = a; in_b = b; in_cin = ci; in_sub = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        for (int g = 0; g < 30 && (q16.size() != 0 || q32.size() != 0); g++) tick();
        chk("drain16 empty", 64'(q16.size()), 64'd0);
        chk("drain32 empty", 64'(q32.size()), 64'd0);
    endtask

    task automatic exp_out(input string t, input logic [15:0] s16, input logic c16, v16,
                           input logic [31:0] s32, input logic c32, v32);
        chk({t, " valid16"}, 64'(o16_valid), 64'd1);
        chk({t, " sum16"},   64'(o16_sum),   64'(s16));
        chk({t, " cout16"},  64'(o16_cout),  64'(c16));
        chk({t, " ovf16"},   64'(o16_ovf),   64'(v16));
        chk({t, " valid32"}, 64'(o32_valid), 64'd1);
        chk({t, " sum32"},   64'(o32_sum),   64'(s32));
        chk({t, " cout32"},  64'(o32_cout),  64'(c32));
        chk({t, " ovf32"},   64'(o32_ovf),   64'(v32));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst valid16", 64'(o16_valid), 64'd0);
        chk("rst sum16",   64'(o16_sum),   64'd0);
        chk("rst cout16",  64'(o16_cout),  64'd0);
        chk("rst ovf16",   64'(o16_ovf),   64'd0);
        chk("rst ready16", 64'(i16_ready), 64'd1);
        chk("rst valid32", 64'(o32_valid), 64'd0);
        chk("rst ready32", 64'(i32_ready), 64'd1);
        @(posedge clk);
        #1;

        // Carry through every group
        send(32'h0000FFFF, 32'h1, 1'b0, 1'b0);
        idle(3);
        exp_out("t1", 16'h0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        tick();

        // Subtraction: borrow, signed overflow, B=0
        send(32'h3, 32'h5, 1'b0, 1'b1);
        send(32'h8000, 32'h1, 1'b0, 1'b1);
        send(32'hABCD, 32'h0, 1'b0, 1'b1);
        idle(1);
        exp_out("t2a", 16'hFFFE, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        tick();
        exp_out("t2b", 16'h7FFF, 1'b1, 1'b1, 32'h0000_7FFF, 1'b1, 1'b0);
        tick();
        exp_out("t2c", 16'hABCD, 1'b1, 1'b0, 32'h0000_ABCD, 1'b1, 1'b0);
        tick();

        // Back-to-back random stream
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain();

        // Backpressure: fill, hold, release
        chk_lat = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
        in_a = $urandom; in_b = $urandom; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
        idle(6);
        chk("t4 ready16 stalled", 64'(i16_ready), 64'd0);
        chk("t4 ready32 stalled", 64'(i32_ready), 64'd0);
        chk("t4 held valid16", 64'(o16_valid), 64'd1);
        chk("t4 accepted16", 64'(q16.size()), 64'd4);
        chk("t4 accepted32", 64'(q32.size()), 64'd4);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4 take+accept16", 64'(q16.size()), 64'd4);
        drain();

        // Reset with beats in flight
        chk_lat = 1'b1;
        for (int i = 0; i < 5; i++) send($urandom, $urandom, 1'($urandom), 1'b0);
        rst = 1'b1;
        #1;
        chk("t5 valid16 in rst", 64'(o16_valid), 64'd0);
        chk("t5 valid32 in rst", 64'(o32_valid), 64'd0);
        q16.delete();
        q32.delete();
        #1 rst = 1'b0;
        idle(6);
        chk("t5 valid16 quiet", 64'(o16_valid), 64'd0);
        chk("t5 valid32 quiet", 64'(o32_valid), 64'd0);
        send(32'h1234, 32'h1111, 1'b0, 1'b0);
        idle(3);
        exp_out("t5", 16'h2345, 1'b0, 1'b0, 32'h0000_2345, 1'b0, 1'b0);
        tick();

        // Signed overflow at the 32-bit MSB
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        idle(3);
        exp_out("t6", 16'h0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        tick();

        // Random valid and ready
        chk_lat = 1'b0;
        for (int i = 0; i < 60; i++) begin
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
